// File: rtl/switch_button_reader.sv
// Read-only device-bus peripheral: synchronised, periodically sampled switches and
// debounced push-buttons with sticky press flags that clear when the CPU reads them.
module switch_button_reader #(
  parameter logic [11:0] SWADDR    = 12'h070,
  parameter logic [11:0] BTNADDR   = 12'h074,
  parameter int          DB_CYCLES = 100000,
  parameter int          CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dv_rd_e,
  input  logic [11:0] dv_addr,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [31:0] data_tocpu
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};

  logic [23:0]            r_sw_m;
  logic [23:0]            r_sw_s;
  logic [4:0]             r_btn_m;
  logic [4:0]             r_btn_s;
  logic [CNT_W-1:0]       r_tick;
  logic [23:0]            r_sw_reg;
  logic [4:0]             r_btn_db;
  logic [4:0]             r_btn_flag;
  logic [4:0][CNT_W-1:0]  r_cnt;

  logic [4:0]             w_db_next;
  logic [4:0][CNT_W-1:0]  w_cnt_next;
  logic [4:0]             w_press;
  logic                   w_rd_btn;

  assign w_rd_btn = dv_rd_e & (dv_addr == BTNADDR);
  assign w_press  = w_db_next & ~r_btn_db;

  // Per-button debounce: accept a new level only after DB_CYCLES consecutive mismatches
  always_comb begin
    w_db_next  = r_btn_db;
    w_cnt_next = r_cnt;
    for (int i = 0; i < 5; i++) begin
      if (r_btn_s[i] == r_btn_db[i]) begin
        w_cnt_next[i] = C_ZERO;
      end else if (r_cnt[i] == C_LAST) begin
        w_db_next[i]  = r_btn_s[i];
        w_cnt_next[i] = C_ZERO;
      end else begin
        w_cnt_next[i] = r_cnt[i] + C_ONE;
      end
    end
  end

  // Synchronisers, switch sample tick, debounce state and sticky press flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_m     <= 24'd0;
      r_sw_s     <= 24'd0;
      r_btn_m    <= 5'd0;
      r_btn_s    <= 5'd0;
      r_tick     <= C_ZERO;
      r_sw_reg   <= 24'd0;
      r_btn_db   <= 5'd0;
      r_btn_flag <= 5'd0;
      r_cnt      <= {5{C_ZERO}};
    end else begin
      r_sw_m  <= sw;
      r_sw_s  <= r_sw_m;
      r_btn_m <= btn;
      r_btn_s <= r_btn_m;
      if (r_tick == C_LAST) begin
        r_tick   <= C_ZERO;
        r_sw_reg <= r_sw_s;
      end else begin
        r_tick   <= r_tick + C_ONE;
        r_sw_reg <= r_sw_reg;
      end
      r_btn_db   <= w_db_next;
      r_cnt      <= w_cnt_next;
      // A press on the same edge as a read-clear survives the clear
      r_btn_flag <= (w_rd_btn ? 5'd0 : r_btn_flag) | w_press;
    end
  end

  // Zero-wait-state read decode
  always_comb begin
    data_tocpu = 32'd0;
    if (dv_rd_e) begin
      case (dv_addr)
        SWADDR:  data_tocpu = {8'd0, r_sw_reg};
        BTNADDR: data_tocpu = {19'd0, r_btn_flag, 3'd0, r_btn_db};
        default: data_tocpu = 32'd0;
      endcase
    end else begin
      data_tocpu = 32'd0;
    end
  end

endmodule

// File: tb/tb_switch_button_reader.sv
// Directed bench for switch_button_reader: literal expectations per phase plus a
// window-based behavioural model compared against data_tocpu on every cycle.
module tb_switch_button_reader;

  localparam logic [11:0] SWADDR  = 12'h070;
  localparam logic [11:0] BTNADDR = 12'h074;
  localparam int          DB      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv_rd_e = 1'b0;
  logic [11:0] dv_addr = 12'h000;
  logic [23:0] sw = 24'h000000;
  logic [4:0]  btn = 5'h00;
  logic [31:0] data_tocpu;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  switch_button_reader #(
    .SWADDR(SWADDR), .BTNADDR(BTNADDR), .DB_CYCLES(DB), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .dv_rd_e(dv_rd_e), .dv_addr(dv_addr),
    .sw(sw), .btn(btn), .data_tocpu(data_tocpu)
  );

  always #5 clk = ~clk;

  // Model: inputs reach the logic two edges late; a button level flips once the last
  // DB synchronised samples since reset all disagree with it; switches load every DB edges.
  logic [23:0] m_sw1 = 24'h0, m_sw2 = 24'h0, m_swreg = 24'h0;
  logic [4:0]  m_b1 = 5'h0, m_b2 = 5'h0, m_db = 5'h0, m_flag = 5'h0;
  logic [4:0]  m_hist [DB];
  int          m_n = 0;
  int          m_hv = 0;

  always @(posedge clk) begin
    logic [4:0] nd;
    bit all_diff;
    if (rst) begin
      m_sw1 = 24'h0; m_sw2 = 24'h0; m_swreg = 24'h0;
      m_b1 = 5'h0; m_b2 = 5'h0; m_db = 5'h0; m_flag = 5'h0;
      m_n = 0; m_hv = 0;
      for (int k = 0; k < DB; k++) m_hist[k] = 5'h0;
    end else begin
      m_n = m_n + 1;
      if (m_n % DB == 0) m_swreg = m_sw2;
      for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_b2;
      if (m_hv < DB) m_hv = m_hv + 1;
      nd = m_db;
      for (int i = 0; i < 5; i++) begin
        all_diff = (m_hv >= DB);
        for (int k = 0; k < DB; k++)
          if (m_hist[k][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_db[i];
      end
      m_flag = ((dv_rd_e && dv_addr == BTNADDR) ? 5'h0 : m_flag) | (nd & ~m_db);
      m_db = nd;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_b2 = m_b1;   m_b1 = btn;
    end
  end

  function automatic logic [31:0] model_read(input logic rd, input logic [11:0] a);
    if (!rd) return 32'h0;
    if (a == SWADDR) return {8'h0, m_swreg};
    if (a == BTNADDR) return {19'h0, m_flag, 3'b000, m_db};
    return 32'h0;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] want;
    if (chk_en) begin
      want = model_read(dv_rd_e, dv_addr);
      n_cmp++;
      if (data_tocpu !== want) begin
        n_err++;
        $display("FAIL model t=%0t rd=%0b addr=%h data_tocpu=%h expected=%h",
                 $time, dv_rd_e, dv_addr, data_tocpu, want);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] want);
    @(negedge clk);
    n_cmp++;
    if (data_tocpu !== want) begin
      n_err++;
      $display("FAIL %s: data_tocpu=%h expected=%h", name, data_tocpu, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sw = 24'h0; btn = 5'h0; dv_rd_e = 1'b0; dv_addr = 12'h000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all inputs high, then read both registers
    rst = 1'b1; sw = 24'hFFFFFF; btn = 5'h1F;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0; dv_rd_e = 1'b1; dv_addr = SWADDR;
    chk("rst_sw", 32'h0);
    tick();
    dv_addr = BTNADDR;
    chk("rst_btn", 32'h0);
    tick();

    // Switch sampling on the tick boundary
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin sw = 24'hA5C3F0; dv_rd_e = 1'b1; dv_addr = SWADDR; end
      if (c == 5) sw = 24'h123456;
      if (c == 9) dv_addr = 12'h060;
      if (c == 3) chk("sw_before_tick", 32'h0);
      if (c == 4) chk("sw_first_tick", 32'h00A5C3F0);
      if (c == 7) chk("sw_held", 32'h00A5C3F0);
      if (c == 8) chk("sw_second_tick", 32'h00123456);
      if (c == 9) chk("rd_other_addr", 32'h0);
      tick();
    end

    // Debounce: held press, short glitch, exactly-DB pulse
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 0)  begin btn = 5'b00100; dv_rd_e = 1'b1; dv_addr = BTNADDR; end
      if (c == 8)  btn = 5'b00101;
      if (c == 11) btn = 5'b00100;
      if (c == 17) begin btn = 5'b00101; dv_rd_e = 1'b0; end
      if (c == 21) btn = 5'b00100;
      if (c == 24) dv_rd_e = 1'b1;
      if (c == 25) dv_rd_e = 1'b0;
      if (c == 5)  chk("db_before", 32'h0);
      if (c == 6)  chk("db_rise", 32'h00000404);
      if (c == 7)  chk("flag_cleared", 32'h00000004);
      if (c == 16) chk("glitch_ignored", 32'h00000004);
      if (c == 24) chk("pulse_exact_db", 32'h00000105);
      tick();
    end

    // Sticky flag survives release; switch read does not clear it
    do_reset();
    for (int c = 0; c < 21; c++) begin
      if (c == 0)  btn = 5'b10000;
      if (c == 8)  btn = 5'b00000;
      if (c == 15) begin dv_rd_e = 1'b1; dv_addr = SWADDR; end
      if (c == 16) dv_addr = BTNADDR;
      if (c == 18) dv_rd_e = 1'b0;
      if (c == 19) dv_rd_e = 1'b1;
      if (c == 20) dv_rd_e = 1'b0;
      if (c == 15) chk("sw_read_no_clear", 32'h0);
      if (c == 16) chk("sticky_flag", 32'h00001000);
      if (c == 17) chk("second_cycle_clear", 32'h0);
      if (c == 19) chk("next_read_clear", 32'h0);
      tick();
    end

    // Press on the same edge as a read-clear
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 0)  btn = 5'b00001;
      if (c == 4)  btn = 5'b00000;
      if (c == 7)  btn = 5'b00010;
      if (c == 12) begin dv_rd_e = 1'b1; dv_addr = BTNADDR; end
      if (c == 14) dv_rd_e = 1'b0;
      if (c == 12) chk("simul_pre", 32'h00000100);
      if (c == 13) chk("simul_press_wins", 32'h00000202);
      tick();
    end

    // Reset while a debounce count is in progress
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c == 0) begin btn = 5'b01000; dv_rd_e = 1'b1; dv_addr = BTNADDR; end
      if (c == 4) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      if (c == 5)  chk("midrst_cleared", 32'h0);
      if (c == 10) chk("midrst_no_early", 32'h0);
      if (c == 11) chk("midrst_full_wait", 32'h00000808);
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
